// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain.
// Signals:
//   in_valid/in_data/in_ready     upstream valid/ready channel into stage 0
//   out_valid/out_data/out_ready  downstream valid/ready channel from the last stage
//   hold                          stall request, freezes every stage
//   flush                         kill request, empties the chain on the next edge
//   occupancy                     registered count of valid stages
// Modports: master = the side driving stimulus and consuming results; slave = the chain itself.
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 1
);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             hold;
  logic             flush;
  logic [OccW-1:0]  occupancy;

  modport master (
    output in_valid, in_data, out_ready, hold, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, hold, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with per-stage valid bits, valid/ready flow control,
// stall (hold), flush and bubble collapsing.
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset, clears valid bits, payload and occupancy
//   bus          pipe_stage_chain_if.slave handshake bundle (in_*, out_*, hold, flush, occupancy)
//   stall_cnt_o  (PIPE_STAGE_STATS_EN only) saturating count of held cycles with work in flight
//   flush_cnt_o  (PIPE_STAGE_STATS_EN only) saturating count of flush cycles that killed work
// Optional feature macro: PIPE_STAGE_STATS_EN adds the two statistics counters.
module pipe_stage_chain #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned DEPTH       = 1,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_stage_chain_if.slave   bus
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 8) begin : g_depth_check
    $error("pipe_stage_chain: DEPTH must be in 1..8");
  end

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OccW-1:0]  occ_q, occ_d;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  // Stage i may load when not held and either it is empty (bubble collapse) or the stage ahead
  // frees up this cycle. A running accumulator avoids a vector that feeds back on itself.
  always_comb begin
    logic acc;
    acc = bus.out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = !bus.hold && (!v_q[i] || acc);
      rdy[i] = acc;
    end
  end

  always_comb begin
    src_v[0] = bus.in_valid;
    src_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (bus.flush) begin
      // Flush beats hold: every stage is killed regardless of stall.
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_d[i] = ZERO_BUBBLE ? '0 : d_q[i];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = src_v[i];
          d_d[i] = (ZERO_BUBBLE && !src_v[i]) ? '0 : src_d[i];
        end
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OccW'(v_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  // Input presented during a flush cycle is dropped, so stage 0 must not signal acceptance.
  assign bus.in_ready  = rdy[0] && !bus.flush;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        busy;

  assign busy = (occ_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.hold && !bus.flush && busy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.flush && busy && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
